// File: rtl/femto_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-target trap.
package femto_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_ARB,
    ST_FETCH,
    ST_DATA
`ifdef FETCH_MISALIGN_TRAP_EN
    , ST_HALT
`endif
  } state_e;

  localparam int unsigned PC_INC = 4;

  localparam logic MEM_SEL_FETCH = 1'b0;
  localparam logic MEM_SEL_DATA  = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of PC-register, hazard, data-request and memory-port signals around the sequencer.
// FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned status output.
interface pc_fetch_sequencer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            pc_load;
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            data_req;
  logic            data_grant;
  logic            data_done;
  logic            mem_req;
  logic            mem_sel;
  logic [XLEN-1:0] mem_addr_fetch;
  logic            mem_ready;
  logic            instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            fetch_misaligned;
`endif

  modport master (
    input  pc_q, stall, branch_taken, branch_target, data_req, mem_ready,
    output pc_d, pc_load, data_grant, data_done, mem_req, mem_sel,
           mem_addr_fetch, instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    , output fetch_misaligned
`endif
  );

  modport slave (
    output pc_q, stall, branch_taken, branch_target, data_req, mem_ready,
    input  pc_d, pc_load, data_grant, data_done, mem_req, mem_sel,
           mem_addr_fetch, instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    , input fetch_misaligned
`endif
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Pending-redirect holder: captures branch targets, lets a newer one overwrite,
// releases on the next PC load, and flags a fetch made stale by a redirect.
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            consume_i,
  input  logic            in_fetch_i,
  output logic            redir_vld_o,
  output logic [XLEN-1:0] redir_tgt_o,
  output logic            squash_o
);

  logic            pend_vld_q, pend_vld_d;
  logic            squash_q, squash_d;
  logic [XLEN-1:0] pend_tgt_q;

  always_comb begin
    pend_vld_d = pend_vld_q;
    if (consume_i)      pend_vld_d = 1'b0;
    else if (capture_i) pend_vld_d = 1'b1;

    // Squash only tracks redirects that land while a fetch is outstanding.
    squash_d = squash_q;
    if (consume_i || !in_fetch_i) squash_d = 1'b0;
    else if (capture_i)           squash_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
      squash_q   <= squash_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture_i && !consume_i) pend_tgt_q <= target_i;
  end

  // A live pulse wins over anything already pending.
  assign redir_vld_o = capture_i | pend_vld_q;
  assign redir_tgt_o = capture_i ? target_i : pend_tgt_q;
  assign squash_o    = squash_q | (capture_i & in_fetch_i);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Drives the PC register and arbitrates one memory port between fetch and data access.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt the sequencer instead of being aligned.
module pc_fetch_sequencer
  import femto_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC)
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_sequencer_if.master   bus
);

  state_e          state_q, state_d;
  logic            out_en_q;
  logic            last_q, last_d;
  logic            pc_load;
  logic [XLEN-1:0] pc_d;
  logic            data_done;
  logic            instr_valid;
  logic            redir_vld;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] tgt_load;
  logic            squash;

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect (
    .clk         (clk),
    .rst         (rst),
    .capture_i   (bus.branch_taken && (state_q != ST_BOOT)),
    .target_i    (bus.branch_target),
    .consume_i   (pc_load),
    .in_fetch_i  (state_q == ST_FETCH),
    .redir_vld_o (redir_vld),
    .redir_tgt_o (redir_tgt),
    .squash_o    (squash)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic tgt_bad;
  logic misaligned_q;
  assign tgt_bad  = |redir_tgt[1:0];
  assign tgt_load = redir_tgt;
`else
  assign tgt_load = redir_tgt & ~XLEN'(3);
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    pc_load     = 1'b0;
    pc_d        = '0;
    data_done   = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (out_en_q) begin
          pc_load = 1'b1;
          pc_d    = RESET_VEC;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (redir_vld) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (tgt_bad) state_d = ST_HALT;
          else
`endif
          begin
            pc_load = 1'b1;
            pc_d    = tgt_load;
          end
        end else if (bus.data_req && (!last_q || bus.stall)) begin
          state_d = ST_DATA;
        end else if (!bus.stall) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.mem_ready) begin
          last_d      = 1'b0;
          state_d     = ST_ARB;
          instr_valid = !squash;
          if (redir_vld) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt_bad) state_d = ST_HALT;
            else
`endif
            begin
              pc_load = 1'b1;
              pc_d    = tgt_load;
            end
          end else begin
            pc_load = 1'b1;
            pc_d    = bus.pc_q + XLEN'(PC_INC);
          end
        end
      end
      ST_DATA: begin
        if (bus.mem_ready) begin
          data_done = 1'b1;
          last_d    = 1'b1;
          state_d   = ST_ARB;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // out_en_q keeps BOOT quiet until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_BOOT;
      out_en_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_en_q <= 1'b1;
      last_q   <= last_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    misaligned_q <= 1'b0;
    else if (state_d == ST_HALT) misaligned_q <= 1'b1;
  end
  assign bus.fetch_misaligned = misaligned_q;
`endif

  assign bus.pc_load        = pc_load;
  assign bus.pc_d           = pc_d;
  assign bus.data_done      = data_done;
  assign bus.instr_valid    = instr_valid;
  assign bus.mem_req        = (state_q == ST_FETCH) || (state_q == ST_DATA);
  assign bus.mem_sel        = (state_q == ST_DATA) ? MEM_SEL_DATA : MEM_SEL_FETCH;
  assign bus.data_grant     = (state_q == ST_DATA);
  assign bus.mem_addr_fetch = (state_q == ST_FETCH) ? bus.pc_q : '0;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: per-cycle vector table plus reset corner sequences.
module tb_pc_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.XLEN(32)) bus ();

  pc_fetch_sequencer #(.XLEN(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // PC register the sequencer controls.
  logic [31:0] pc_reg = 32'hDEAD_BEE0;
  always @(posedge clk) if (bus.pc_load) pc_reg <= bus.pc_d;
  assign bus.pc_q = pc_reg;

  typedef struct {
    string       name;
    bit          rst;
    bit          stall;
    bit          bt;
    logic [31:0] tgt;
    bit          dreq;
    bit          rdy;
    bit          ld;
    logic [31:0] pcd;
    bit          req;
    bit          sel;
    bit          gnt;
    bit          done;
    bit          iv;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(string n, bit r, bit st, bit b, logic [31:0] tg, bit dq, bit rd,
                              bit ld, logic [31:0] pd, bit rq, bit sl, bit gn, bit dn, bit iv,
                              logic [31:0] ad);
    vec_t v;
    v.name = n; v.rst = r; v.stall = st; v.bt = b; v.tgt = tg; v.dreq = dq; v.rdy = rd;
    v.ld = ld; v.pcd = pd; v.req = rq; v.sel = sl; v.gnt = gn; v.done = dn; v.iv = iv;
    v.addr = ad;
    vecs.push_back(v);
  endfunction

  task automatic chk(string n, logic [95:0] got, logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, got, exp);
    end
  endtask

  function automatic logic [95:0] pack_out(bit ld, logic [31:0] pd, bit rq, bit sl, bit gn,
                                           bit dn, bit iv, logic [31:0] ad);
    return {26'd0, ld, rq, sl, gn, dn, iv, pd, ad};
  endfunction

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.data_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    idle_inputs();

    // name            rst st bt tgt            dq rd   ld pcd            rq sl gn dn iv addr
    add("rst_hold",     0, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("rst_hold",     0, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("boot_wait",    1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("boot_load",    1, 0, 0, 0,             0, 0,   1, 0,             0, 0, 0, 0, 0, 0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_0",      1, 0, 0, 0,             0, 1,   1, 'h4,           1, 0, 0, 0, 1, 'h0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_4",      1, 0, 0, 0,             0, 1,   1, 'h8,           1, 0, 0, 0, 1, 'h4);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_8_wait", 1, 0, 0, 0,             0, 0,   0, 0,             1, 0, 0, 0, 0, 'h8);
    add("rst_midfetch", 0, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("boot_wait",    1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("boot_load",    1, 0, 0, 0,             0, 0,   1, 0,             0, 0, 0, 0, 0, 0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("refetch_0",    1, 0, 0, 0,             0, 1,   1, 'h4,           1, 0, 0, 0, 1, 'h0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("refetch_4",    1, 0, 0, 0,             0, 1,   1, 'h8,           1, 0, 0, 0, 1, 'h4);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("refetch_8",    1, 0, 0, 0,             0, 1,   1, 'hC,           1, 0, 0, 0, 1, 'h8);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_c",      1, 0, 0, 0,             0, 1,   1, 'h10,          1, 0, 0, 0, 1, 'hC);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("br_wait1",     1, 0, 0, 0,             0, 0,   0, 0,             1, 0, 0, 0, 0, 'h10);
    add("br_wait2",     1, 0, 1, 'h100,         0, 0,   0, 0,             1, 0, 0, 0, 0, 'h10);
    add("br_wait3",     1, 0, 0, 0,             0, 0,   0, 0,             1, 0, 0, 0, 0, 'h10);
    add("br_squash",    1, 0, 0, 0,             0, 1,   1, 'h100,         1, 0, 0, 0, 0, 'h10);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_100",    1, 0, 0, 0,             0, 1,   1, 'h104,         1, 0, 0, 0, 1, 'h100);
    add("fair_arb",     1, 0, 0, 0,             1, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fair_data1",   1, 0, 0, 0,             1, 1,   0, 0,             1, 1, 1, 1, 0, 0);
    add("fair_arb",     1, 0, 0, 0,             1, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fair_fetch1",  1, 0, 0, 0,             1, 1,   1, 'h108,         1, 0, 0, 0, 1, 'h104);
    add("fair_arb",     1, 0, 0, 0,             1, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fair_data2",   1, 0, 0, 0,             1, 1,   0, 0,             1, 1, 1, 1, 0, 0);
    add("fair_arb",     1, 0, 0, 0,             1, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fair_fetch2",  1, 0, 0, 0,             1, 1,   1, 'h10C,         1, 0, 0, 0, 1, 'h108);
    add("stall_arb",    1, 1, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("stall_arb",    1, 1, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("stall_arb",    1, 1, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("stall_rel",    1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_10c",    1, 0, 0, 0,             0, 1,   1, 'h110,         1, 0, 0, 0, 1, 'h10C);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fstall_wait",  1, 1, 0, 0,             0, 0,   0, 0,             1, 0, 0, 0, 0, 'h110);
    add("fstall_done",  1, 1, 0, 0,             0, 1,   1, 'h114,         1, 0, 0, 0, 1, 'h110);
    add("wrap_redir",   1, 0, 1, 'hFFFF_FFFC,   0, 0,   1, 'hFFFF_FFFC,   0, 0, 0, 0, 0, 0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("wrap_fetch",   1, 0, 0, 0,             0, 1,   1, 'h0,           1, 0, 0, 0, 1, 'hFFFF_FFFC);
`ifdef FETCH_MISALIGN_TRAP_EN
    add("misalign_trap",1, 0, 1, 'h102,         0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("halt",         1, 0, 0, 0,             1, 1,   0, 0,             0, 0, 0, 0, 0, 0);
    add("halt",         1, 0, 0, 0,             1, 1,   0, 0,             0, 0, 0, 0, 0, 0);
    add("halt",         1, 0, 0, 0,             1, 1,   0, 0,             0, 0, 0, 0, 0, 0);
`else
    add("misalign_fix", 1, 0, 1, 'h102,         0, 0,   1, 'h100,         0, 0, 0, 0, 0, 0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_100b",   1, 0, 0, 0,             0, 1,   1, 'h104,         1, 0, 0, 0, 1, 'h100);
    add("dbr_arb",      1, 0, 0, 0,             1, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("dbr_wait",     1, 0, 1, 'h200,         1, 0,   0, 0,             1, 1, 1, 0, 0, 0);
    add("dbr_done",     1, 0, 0, 0,             1, 1,   0, 0,             1, 1, 1, 1, 0, 0);
    add("dbr_redir",    1, 0, 0, 0,             0, 0,   1, 'h200,         0, 0, 0, 0, 0, 0);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_200",    1, 0, 0, 0,             0, 1,   1, 'h204,         1, 0, 0, 0, 1, 'h200);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("live_squash",  1, 0, 1, 'h300,         0, 1,   1, 'h300,         1, 0, 0, 0, 0, 'h204);
    add("arb",          1, 0, 0, 0,             0, 0,   0, 0,             0, 0, 0, 0, 0, 0);
    add("fetch_300",    1, 0, 0, 0,             0, 1,   1, 'h304,         1, 0, 0, 0, 1, 'h300);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst               = vecs[i].rst;
      bus.stall         = vecs[i].stall;
      bus.branch_taken  = vecs[i].bt;
      bus.branch_target = vecs[i].tgt;
      bus.data_req      = vecs[i].dreq;
      bus.mem_ready     = vecs[i].rdy;
      #2;
      chk($sformatf("%s[%0d]", vecs[i].name, i),
          pack_out(bus.pc_load, bus.pc_d, bus.mem_req, bus.mem_sel, bus.data_grant,
                   bus.data_done, bus.instr_valid, bus.mem_addr_fetch),
          pack_out(vecs[i].ld, vecs[i].pcd, vecs[i].req, vecs[i].sel, vecs[i].gnt,
                   vecs[i].done, vecs[i].iv, vecs[i].addr));
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misaligned_sticky", 96'(bus.fetch_misaligned), 96'd1);
`endif

    // Reset, then wait (bounded) for the boot load and the first fetch, then
    // drop reset while that fetch is stalled on mem_ready.
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #2;
    chk("reset_quiet", 96'({bus.mem_req, bus.pc_load}), 96'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misaligned_cleared", 96'(bus.fetch_misaligned), 96'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      #2;
      if (bus.pc_load) seen = 1'b1;
    end
    chk("boot_load_seen", 96'(seen), 96'd1);
    chk("boot_load_vec", 96'(bus.pc_d), 96'h0);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      #2;
      if (bus.mem_req) seen = 1'b1;
    end
    chk("first_fetch_seen", 96'(seen), 96'd1);
    chk("first_fetch_addr", 96'({bus.mem_sel, bus.mem_addr_fetch}), 96'h0);
    @(negedge clk);
    #2;
    chk("fetch_held", 96'({bus.mem_req, bus.pc_load}), 96'b10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_abort", 96'({bus.mem_req, bus.pc_load, bus.instr_valid}), 96'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sequences the PC register (drives its load-enable and D input) and arbitrates a single shared memory port between instruction fetch and load/store data access.
- Applies branch/jump redirects, squashes a fetch made stale by a redirect, and alternates priority so neither requester starves.
- Sits between the hazard/branch logic, the PC register and the unified memory.

Parameters:
- XLEN, 32: address/PC width.
- RESET_VEC, 32'h0000_0000: first PC loaded after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_q  in  XLEN  current PC register output.
- pc_d  out  XLEN  next PC value to PC register D.
- pc_load  out  1  PC register load enable.
- stall  in  1  hazard unit: do not start a new fetch.
- branch_taken  in  1  redirect request, 1-cycle pulse.
- branch_target  in  XLEN  redirect address, valid with branch_taken.
- data_req  in  1  execute stage requests a memory data access; held until data_done.
- data_grant  out  1  memory port owned by data access.
- data_done  out  1  data access completes this cycle.
- mem_req  out  1  memory transaction active.
- mem_sel  out  1  0 = fetch, 1 = data.
- mem_addr_fetch  out  XLEN  fetch address (= pc_q during FETCH).
- mem_ready  in  1  memory completes current transaction this cycle.
- instr_valid  out  1  fetched instruction valid this cycle.

Behaviour:
- While rst is low:
  - State = BOOT; all outputs 0.
  - redirect_pending = 0; last_was_data = 0.
- States are BOOT, ARB, FETCH and DATA; HALT is added only under the optional feature.
- BOOT (first cycle after reset release):
  - pc_load = 1, pc_d = RESET_VEC.
  - Next state: ARB.
- ARB, evaluated in priority order:
  1. If a live or pending redirect exists: pc_load = 1, pc_d = target, clear pending, stay in ARB.
  2. Else if data_req and (last_was_data = 0 or stall or no fetch possible): go to DATA.
  3. Else if !stall: go to FETCH.
  4. Else: stay in ARB.
- FETCH:
  - mem_req = 1, mem_sel = 0, mem_addr_fetch = pc_q.
  - Held until mem_ready; no abort.
  - On mem_ready: pc_load = 1; last_was_data = 0; go to ARB.
  - On mem_ready, pc_d = branch_target if branch_taken is live, else the pending target if a redirect is pending, else pc_q + 4.
  - On mem_ready, instr_valid = 1 only if no redirect arrived during this fetch, including the same cycle. Otherwise the fetch is squashed: instr_valid = 0 and the PC still loads the target.
  - pc_q + 4 wraps modulo 2^XLEN (FFFF_FFFC -> 0000_0000).
- DATA:
  - mem_req = 1, mem_sel = 1, data_grant = 1.
  - On mem_ready: data_done = 1, last_was_data = 1, go to ARB.
  - PC is untouched.
- Redirect capture:
  - A branch_taken pulse in any state other than BOOT latches the target into redirect_pending.
  - A newer pulse overwrites an older pending one.
  - The pending redirect is consumed at the next pc_load.
- Latency and throughput:
  - Minimum 2 cycles per instruction (ARB + 1-cycle FETCH).
  - A data access inserts 2+ cycles.
- Fairness: with data_req held continuously and stall = 0, grants alternate fetch/data.
- stall does not affect a FETCH or DATA already in progress.
- Asynchronous reset mid-transaction abandons it: mem_req drops immediately.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit).
  - Any redirect target with target[1:0] != 0 is not loaded.
  - fetch_misaligned goes high and stays high (sticky) until reset.
  - FSM enters HALT: no mem_req, no pc_load; data_req is never granted.
- Undefined: target[1:0] is forced to 2'b00 before loading; no HALT state.

Decomposition:
- Shared package femto_pkg:
  - State encoding typedef (BOOT/ARB/FETCH/DATA/HALT).
  - PC_INC = 4.
  - MEM_SEL_FETCH = 0, MEM_SEL_DATA = 1.
  - Default RESET_VEC.
- One natural sub-module, pc_redirect_buf: the pending-redirect register with capture/overwrite/consume and the squash flag.

Test Plan:
- Reset: rst low mid-FETCH, release -> mem_req = 0 immediately; next cycle pc_load = 1, pc_d = 0x0; sequential fetches 0x0, 0x4, 0x8 with instr_valid each.
- Redirect during fetch: mem_ready delayed 3 cycles at pc_q = 0x10, branch_taken with 0x100 in wait cycle 2 -> instr_valid = 0 on completion, pc_d = 0x100, then fetch from 0x100 valid.
- Arbitration fairness: data_req held high, stall = 0, mem_ready = 1 always -> mem_sel sequence 1,0,1,0; data_done on every DATA completion.
- Stall: stall = 1 in ARB, data_req = 0 -> no mem_req, no pc_load for the stall duration; release -> FETCH of the unchanged pc_q.
- Wrap: pc_q = 0xFFFF_FFFC fetch completes -> pc_d = 0x0000_0000.
- Misaligned target: branch_target = 0x102. With FETCH_MISALIGN_TRAP_EN defined -> fetch_misaligned = 1, no further mem_req. Undefined -> pc_d = 0x100.
